ram_sp_sync: RTL and testbench

Parametrised synchronous single-port RAM, the clocked successor to the team's asynchronous 8-bit × 1K RAM. It adds configurable width and depth, a registered read with a valid strobe, and a selectable read-during-write mode. A built-in fill engine initialises every location after reset and on request. Out-of-range addresses are flagged. It serves as the general scratch/buffer memory behind bus slaves and test benches in the design.

---
 rtl/ram_sp_sync_if.sv | 52 +++++
 rtl/ram_sp_sync.sv | 134 +++++++++++++
 tb/tb_ram_sp_sync.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ram_sp_sync_if.sv
// Bus bundle for ram_sp_sync: access port, fill control and status strobes.
// The master drives requests; the slave (the RAM) returns registered
// read data and status.
interface ram_sp_sync_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    // Access request
    logic              cs;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;

    // Access response
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              addr_err;

    // Fill control and status
    logic              fill_req;
    logic [DATA_W-1:0] fill_val;
    logic              busy;
    logic              done;

    modport master (
        output cs,
        output wr,
        output addr,
        output data_in,
        output fill_req,
        output fill_val,
        input  data_out,
        input  rd_valid,
        input  addr_err,
        input  busy,
        input  done
    );

    modport slave (
        input  cs,
        input  wr,
        input  addr,
        input  data_in,
        input  fill_req,
        input  fill_val,
        output data_out,
        output rd_valid,
        output addr_err,
        output busy,
        output done
    );
endinterface

// File: rtl/ram_sp_sync.sv
// Synchronous single-port RAM with registered read, rd_valid strobe,
// selectable read-during-write behaviour, out-of-range flagging and a
// fill engine that writes a pattern to every implemented location after
// reset and whenever a fill is requested.
module ram_sp_sync #(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 10,
    parameter int                 DEPTH    = 1 << ADDR_W,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0,
    parameter int                 RDW_MODE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_sp_sync_if.slave  bus
);

    // DEPTH may equal 2**ADDR_W, so the range compare needs one extra bit.
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    // Last location written by a fill; the counter stops here and never wraps.
    localparam logic [ADDR_W-1:0] LAST_LOC = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    // Storage: deliberately not reset, the fill engine restores contents.
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] pat_q;
    logic [DATA_W-1:0] data_out_q;
    logic              rd_valid_q;
    logic              addr_err_q;
    logic              busy_q;
    logic              done_q;

    logic              in_range;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign in_range = ({1'b0, bus.addr} < DEPTH_X);

    // Write-port steering: fill writes in FILL, user writes in IDLE unless
    // a fill request pre-empts the access or the address is out of range.
    // Writes are suppressed while reset is held so the aborted fill cannot
    // disturb anything beyond what the restarted fill rewrites anyway.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = pat_q;
        if (rst_n) begin
            if (state_q == ST_FILL) begin
                mem_we = 1'b1;
            end else if (!bus.fill_req && bus.cs && bus.wr && in_range) begin
                mem_we    = 1'b1;
                mem_waddr = bus.addr;
                mem_wdata = bus.data_in;
            end
        end
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM with registered outputs: fill sequencing, access
    // acceptance, read data capture and one-cycle strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FILL;
            cnt_q      <= '0;
            pat_q      <= INIT_VAL;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                ST_FILL: begin
                    // Access and fill requests are ignored while filling.
                    if (cnt_q == LAST_LOC) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.fill_req) begin
                        // Fill wins over a simultaneous access, which is dropped.
                        pat_q   <= bus.fill_val;
                        cnt_q   <= '0;
                        state_q <= ST_FILL;
                        busy_q  <= 1'b1;
                    end else if (bus.cs) begin
                        rd_valid_q <= 1'b1;
                        if (!in_range) begin
                            addr_err_q <= 1'b1;
                            data_out_q <= '0;
                        end else if (bus.wr && (RDW_MODE == 1)) begin
                            data_out_q <= bus.data_in;
                        end else begin
                            // Read-first: the array still holds the old word here.
                            data_out_q <= mem[bus.addr];
                        end
                    end
                end
                default: begin
                    state_q <= ST_FILL;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.addr_err = addr_err_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_ram_sp_sync.sv
// Self-checking bench for ram_sp_sync: directed and random accesses against
// an array reference model, with a scoreboard queue drained by a monitor.
module tb_ram_sp_sync;
    localparam int         DW    = 8;
    localparam int         AW    = 10;
    localparam int         DEPTH = 1000;
    localparam logic [7:0] INIT  = 8'h5A;
    localparam int         RDW   = 0;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_sp_sync_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ram_sp_sync #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .INIT_VAL(INIT), .RDW_MODE(RDW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    exp_t       q[$];
    logic [7:0] mem_m [0:DEPTH-1];
    logic [7:0] last_out = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void model_fill(input logic [7:0] v);
        for (int i = 0; i < DEPTH; i++) mem_m[i] = v;
    endfunction

    // Issue one access on the next edge and record what must come back.
    task automatic access(input bit w, input int a, input logic [7:0] d);
        exp_t e;
        bus.cs = 1'b1; bus.wr = w; bus.addr = a[AW-1:0]; bus.data_in = d;
        if (a >= DEPTH) begin
            e.data = 8'h00; e.err = 1'b1;
        end else begin
            e.err  = 1'b0;
            e.data = (w && RDW == 1) ? d : mem_m[a];
            if (w) mem_m[a] = d;
        end
        e.cyc = cyc + 1;
        last_out = e.data;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        bus.cs = 1'b0;
        @(posedge clk); #1;
        check("hold_data_out", bus.data_out, last_out);
    endtask

    // Count edges with busy high; poke cs randomly meanwhile (must be ignored).
    task automatic wait_fill();
        int n = 0, rv = 0, dn = 0;
        while (bus.busy === 1'b1 && n < 2000) begin
            if (bus.rd_valid === 1'b1) rv++;
            if (bus.done === 1'b1) dn++;
            bus.cs = 1'($urandom); bus.wr = 1'($urandom);
            bus.addr = AW'($urandom); bus.data_in = 8'($urandom);
            @(posedge clk); #1;
            n++;
        end
        bus.cs = 1'b0;
        check("busy_edges", n, DEPTH);
        check("done_at_end", bus.done, 1);
        check("done_during_busy", dn, 0);
        check("rd_valid_during_fill", rv, 0);
        @(posedge clk); #1;
        check("done_single_pulse", bus.done, 0);
        check("hold_after_fill", bus.data_out, last_out);
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (bus.rd_valid === 1'b1 || bus.addr_err === 1'b1)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe cyc=%0d rd_valid=%b addr_err=%b required none",
                         cyc, bus.rd_valid, bus.addr_err);
            end else begin
                e = q.pop_front();
                if (bus.rd_valid !== 1'b1 || bus.data_out !== e.data ||
                    bus.addr_err !== e.err || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL txn actual cyc=%0d data=%h err=%b valid=%b required cyc=%0d data=%h err=%b",
                             cyc, bus.data_out, bus.addr_err, bus.rd_valid, e.cyc, e.data, e.err);
                end else begin
                    $display("txn cyc=%0d data=%h err=%b", cyc, bus.data_out, bus.addr_err);
                end
            end
        end
    end

    initial begin
        bus.cs = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.data_in = '0;
        bus.fill_req = 1'b0; bus.fill_val = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 1);
        check("rst_data_out", bus.data_out, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_addr_err", bus.addr_err, 0);
        check("rst_done", bus.done, 0);
        rst_n = 1'b1;
        model_fill(INIT);
        wait_fill();

        // Post-reset contents
        access(0, 0, 0); access(0, 500, 0); access(0, 999, 0);

        // Write then read back, back to back
        access(1, 32, 8'hFF); access(1, 64, 8'hAC); access(1, 128, 8'h9B);
        access(1, 256, 8'h8F); access(1, 512, 8'h7F);
        access(0, 32, 0); access(0, 64, 0); access(0, 128, 0);
        access(0, 256, 0); access(0, 512, 0);

        // Read-during-write
        access(1, 64, 8'h11); access(0, 64, 0);
        idle_cycle();

        // Out-of-range, then check nothing aliased
        access(1, 1010, 8'h33); access(0, 1010, 0);
        access(0, 10, 0); access(0, 498, 0); access(0, 999, 0);
        idle_cycle();

        // Random traffic
        repeat (300) begin
            if ($urandom_range(0, 9) == 0) idle_cycle();
            else access(1'($urandom), int'($urandom_range(0, 1023)), 8'($urandom));
        end
        for (int i = 0; i < DEPTH; i++) access(0, i, 0);
        idle_cycle();

        // Fill request colliding with a write
        bus.fill_req = 1'b1; bus.fill_val = 8'hC3;
        bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = 10'd5; bus.data_in = 8'h77;
        @(posedge clk); #1;
        bus.fill_req = 1'b0;
        model_fill(8'hC3);
        wait_fill();
        access(0, 5, 0); access(0, 6, 0);
        idle_cycle();

        // Reset in the middle of a fill
        bus.fill_req = 1'b1; bus.fill_val = 8'hC3;
        @(posedge clk); #1;
        bus.fill_req = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midfill_rst_busy", bus.busy, 1);
        check("midfill_rst_data_out", bus.data_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_fill(INIT);
        last_out = 8'h00;
        wait_fill();
        access(0, 0, 0); access(0, 299, 0);
        idle_cycle();
        idle_cycle();

        check("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
